// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// The result is computed when an op is accepted, then committed to HI/LO after a fixed busy latency.
module mdu_seq #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t        r_state, w_nstate;
    logic [CW-1:0] r_cnt;
    logic          r_done;
    logic [31:0]   r_hi, r_lo, r_phi, r_plo;
    logic          r_pwe;

    logic          w_accept, w_commit, w_bz;
    logic [63:0]   w_smul, w_umul;
    logic [31:0]   w_bsafe, w_absa, w_absb_raw, w_absb;
    logic [31:0]   w_uq, w_ur, w_sq, w_sr, w_dq, w_dr;
    logic [31:0]   w_res_hi, w_res_lo;
    logic          w_res_we;

    assign w_accept = (r_state == S_IDLE) && start && !MDUOp[2];
    assign w_commit = (r_state == S_RUN) && (r_cnt == '0);

    assign w_smul = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_umul = {32'b0, A} * {32'b0, B};

    // Divisor forced to 1 on zero so the dividers never see /0; the commit is suppressed instead.
    assign w_bz       = (B == 32'd0);
    assign w_bsafe    = w_bz ? 32'd1 : B;
    assign w_absa     = A[31] ? (~A + 32'd1) : A;
    assign w_absb_raw = B[31] ? (~B + 32'd1) : B;
    assign w_absb     = w_bz ? 32'd1 : w_absb_raw;
    assign w_uq       = w_absa / w_absb;
    assign w_ur       = w_absa % w_absb;
    assign w_sq       = (A[31] ^ B[31]) ? (~w_uq + 32'd1) : w_uq;
    assign w_sr       = A[31] ? (~w_ur + 32'd1) : w_ur;
    assign w_dq       = A / w_bsafe;
    assign w_dr       = A % w_bsafe;

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        w_res_we = 1'b1;
        case (MDUOp[1:0])
            2'd0: begin w_res_hi = w_smul[63:32]; w_res_lo = w_smul[31:0]; end
            2'd1: begin w_res_hi = w_umul[63:32]; w_res_lo = w_umul[31:0]; end
            2'd2: begin w_res_hi = w_sr; w_res_lo = w_sq; w_res_we = !w_bz; end
            default: begin w_res_hi = w_dr; w_res_lo = w_dq; w_res_we = !w_bz; end
        endcase
    end

    always_comb begin
        w_nstate = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_nstate = S_RUN;
            S_RUN:   if (w_commit) w_nstate = S_IDLE;
            default: w_nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_nstate;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_phi  <= 32'd0;
            r_plo  <= 32'd0;
            r_pwe  <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_accept) begin
                r_phi <= w_res_hi;
                r_plo <= w_res_lo;
                r_pwe <= w_res_we;
                r_cnt <= MDUOp[1] ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
            end else if ((r_state == S_RUN) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_commit && r_pwe) begin
                r_hi <= r_phi;
                r_lo <= r_plo;
            end
            // MTHI/MTLO only land when idle; while running they are dropped.
            if ((r_state == S_IDLE) && start && (MDUOp == 3'd4)) r_hi <= A;
            if ((r_state == S_IDLE) && start && (MDUOp == 3'd5)) r_lo <= A;
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;
endmodule
